miniproject_cpu_cpu_div_cell: RTL and testbench

MINIPROJECT_CPU_CPU_DIV_CELL -- requirements
Module: miniproject_cpu_cpu_div_cell

---
 rtl/miniproject_cpu_div_pkg.sv | 15 +
 rtl/miniproject_cpu_cpu_div_cell_if.sv | 28 ++
 rtl/miniproject_cpu_div_step.sv | 25 ++
 rtl/miniproject_cpu_cpu_div_cell.sv | 152 +++++++++++++++
 tb/tb_miniproject_cpu_cpu_div_cell.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/miniproject_cpu_div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package miniproject_cpu_div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_e;

endpackage

// File: rtl/miniproject_cpu_cpu_div_cell_if.sv
// Request/response bundle of the divider: E_* issued by the pipeline, M_* returned by the cell.
interface miniproject_cpu_cpu_div_cell_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] E_src1;
   logic [WIDTH-1:0] E_src2;
   logic             E_signed;
   logic             E_start;
   logic             E_kill;
   logic             M_div_busy;
   logic             M_div_done;
   logic [WIDTH-1:0] M_div_quot;
   logic [WIDTH-1:0] M_div_rem;
   logic             M_div_by_zero;

   // Handshake: operands are taken on the edge where E_start=1, E_kill=0 and busy is low
   // (or the cell is in its done cycle); M_div_done is a one-cycle valid for quot/rem/by_zero.
   modport master (
      output E_src1, E_src2, E_signed, E_start, E_kill,
      input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
   );

   modport slave (
      input  E_src1, E_src2, E_signed, E_start, E_kill,
      output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
   );

endinterface

// File: rtl/miniproject_cpu_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract divisor if it fits.
module miniproject_cpu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] prem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] prem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // With prem_i < dvs_i the top bit of diff is exactly the borrow.
   always_comb begin
      shifted = {prem_i, bit_i};
      diff    = shifted - {1'b0, dvs_i};
      fits    = ~diff[WIDTH];
      qbit_o  = fits;
      prem_o  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/miniproject_cpu_cpu_div_cell.sv
// Fixed-latency signed/unsigned divider: PREP -> WIDTH x ITER -> FIX -> DONE.
module miniproject_cpu_cpu_div_cell
   import miniproject_cpu_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] E_src1,
   input  logic [WIDTH-1:0] E_src2,
   input  logic             E_signed,
   input  logic             E_start,
   input  logic             E_kill,
   output logic             M_div_busy,
   output logic             M_div_done,
   output logic [WIDTH-1:0] M_div_quot,
   output logic [WIDTH-1:0] M_div_rem,
   output logic             M_div_by_zero
);

   localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] orig_q, orig_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic             sgn_q, sgn_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             byz_q, byz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             byz_out_q, byz_out_d;

   logic [WIDTH-1:0] step_prem;
   logic             step_qbit;

   miniproject_cpu_div_step #(.WIDTH(WIDTH)) u_step (
      .prem_i (prem_q),
      .bit_i  (dvd_q[cnt_q]),
      .dvs_i  (dvs_q),
      .prem_o (step_prem),
      .qbit_o (step_qbit)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      orig_d    = orig_q;
      prem_d    = prem_q;
      quo_d     = quo_q;
      sgn_d     = sgn_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      byz_d     = byz_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      byz_out_d = byz_out_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (E_start) begin
               dvd_d   = E_src1;
               dvs_d   = E_src2;
               orig_d  = E_src1;
               sgn_d   = E_signed;
               state_d = PREP;
            end
         end
         PREP: begin
            if (sgn_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
            if (sgn_q && dvs_q[WIDTH-1]) dvs_d = -dvs_q;
            qneg_d  = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
            rneg_d  = sgn_q & dvd_q[WIDTH-1];
            byz_d   = (dvs_q == '0);
            prem_d  = '0;
            quo_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = ITER;
         end
         ITER: begin
            prem_d = step_prem;
            quo_d  = {quo_q[WIDTH-2:0], step_qbit};
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            // A zero divisor reports the raw dividend, bypassing sign correction.
            quot_d    = byz_q ? '1     : (qneg_q ? -quo_q  : quo_q);
            rem_d     = byz_q ? orig_q : (rneg_q ? -prem_q : prem_q);
            byz_out_d = byz_q;
            state_d   = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (E_kill) begin
         state_d   = IDLE;
         quot_d    = quot_q;
         rem_d     = rem_q;
         byz_out_d = byz_out_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         orig_q    <= '0;
         prem_q    <= '0;
         quo_q     <= '0;
         sgn_q     <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         byz_q     <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         byz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         orig_q    <= orig_d;
         prem_q    <= prem_d;
         quo_q     <= quo_d;
         sgn_q     <= sgn_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         byz_q     <= byz_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         byz_out_q <= byz_out_d;
      end
   end

   assign M_div_busy    = (state_q != IDLE);
   assign M_div_done    = (state_q == DONE);
   assign M_div_quot    = quot_q;
   assign M_div_rem     = rem_q;
   assign M_div_by_zero = byz_out_q;

endmodule

// File: tb/tb_miniproject_cpu_cpu_div_cell.sv
// Directed and randomized checks of the divider against an arithmetic reference model.
module tb_miniproject_cpu_cpu_div_cell;

   localparam int W = 32;
   localparam int LAT = W + 2;

   logic clk = 1'b0;
   logic reset_n;

   miniproject_cpu_cpu_div_cell_if #(.WIDTH(W)) div_if ();

   miniproject_cpu_cpu_div_cell #(.WIDTH(W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .E_src1        (div_if.E_src1),
      .E_src2        (div_if.E_src2),
      .E_signed      (div_if.E_signed),
      .E_start       (div_if.E_start),
      .E_kill        (div_if.E_kill),
      .M_div_busy    (div_if.M_div_busy),
      .M_div_done    (div_if.M_div_done),
      .M_div_quot    (div_if.M_div_quot),
      .M_div_rem     (div_if.M_div_rem),
      .M_div_by_zero (div_if.M_div_by_zero)
   );

   // clock / reset
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model: plain integer division, truncating toward zero
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa, sb;
      if (b == '0) begin
         q = '1; r = a; z = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = W'(sa / sb);
         r = W'(sa % sb);
         z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] q, r;
      logic z;
      model(a, b, s, q, r, z);
      exp_q.push_back(q);
      exp_q.push_back(r);
      exp_q.push_back({{(W-1){1'b0}}, z});
   endtask

   task automatic pop_expected(output logic [W-1:0] q, output logic [W-1:0] r, output logic [W-1:0] z);
      q = exp_q.pop_front();
      r = exp_q.pop_front();
      z = exp_q.pop_front();
   endtask

   // driver: operands + start presented for exactly one (accepting) edge
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      div_if.E_src1   = a;
      div_if.E_src2   = b;
      div_if.E_signed = s;
      div_if.E_start  = 1'b1;
      @(posedge clk);
      #1;
      div_if.E_start  = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (div_if.M_div_done && lat < 0) lat = n;
         if (lat >= 0) break;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int lat;
      logic [W-1:0] eq, er, ez;
      push_expected(a, b, s);
      issue(a, b, s);
      wait_done(lat);
      pop_expected(eq, er, ez);
      check({tag, "_latency"}, W'(lat), W'(LAT));
      check({tag, "_quot"}, div_if.M_div_quot, eq);
      check({tag, "_rem"}, div_if.M_div_rem, er);
      check({tag, "_by_zero"}, {{(W-1){1'b0}}, div_if.M_div_by_zero}, ez);
   endtask

   initial begin
      logic [W-1:0] a, b, eq, er, ez, eq2, er2, ez2;
      logic s;
      int d1, d2, mode;
      bit saw_done;

      reset_n         = 1'b0;
      div_if.E_src1   = '0;
      div_if.E_src2   = '0;
      div_if.E_signed = 1'b0;
      div_if.E_start  = 1'b0;
      div_if.E_kill   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, div_if.M_div_busy}, '0);
      check("reset_done", {31'b0, div_if.M_div_done}, '0);
      check("reset_quot", div_if.M_div_quot, '0);
      check("reset_rem", div_if.M_div_rem, '0);
      check("reset_by_zero", {31'b0, div_if.M_div_by_zero}, '0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // directed operand corners
      run_op("u100_7", 32'd100, 32'd7, 1'b0);
      run_op("s_m7_2", -32'sd7, 32'd2, 1'b1);
      run_op("s_7_m2", 32'd7, -32'sd2, 1'b1);
      run_op("u5_0", 32'd5, 32'd0, 1'b0);
      run_op("s5_0", 32'd5, 32'd0, 1'b1);
      run_op("s_m5_0", -32'sd5, 32'd0, 1'b1);
      run_op("s_minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("u_small_big", 32'd3, 32'hFFFF_FFF0, 1'b0);

      // randomized operands
      for (int i = 0; i < 24; i++) begin
         mode = $urandom_range(0, 4);
         a = $urandom;
         s = 1'(($urandom_range(0, 1)));
         case (mode)
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), a, b, s);
      end

      // kill with start+kill together while idle: kill wins
      div_if.E_start = 1'b1;
      div_if.E_kill  = 1'b1;
      @(posedge clk);
      #1;
      div_if.E_start = 1'b0;
      div_if.E_kill  = 1'b0;
      check("kill_beats_start_busy", {31'b0, div_if.M_div_busy}, '0);

      // abort mid-division: stray start ignored, kill discards result
      run_op("pre_kill", 32'd1000, 32'd9, 1'b0);
      issue(32'd100, 32'd7, 1'b0);
      saw_done = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk);
         #1;
         if (div_if.M_div_done) saw_done = 1'b1;
         if (n == 9) begin
            div_if.E_src1 = 32'd9; div_if.E_src2 = 32'd3; div_if.E_start = 1'b1;
         end
         if (n == 10) div_if.E_start = 1'b0;
         if (n == 19) div_if.E_kill = 1'b1;
         if (n == 20) begin
            div_if.E_kill = 1'b0;
            check("kill_busy_low", {31'b0, div_if.M_div_busy}, '0);
         end
      end
      check("kill_no_done", {31'b0, saw_done}, '0);
      check("kill_quot_kept", div_if.M_div_quot, 32'd111);
      check("kill_rem_kept", div_if.M_div_rem, 32'd1);
      run_op("after_kill_9_3", 32'd9, 32'd3, 1'b0);

      // back-to-back: start held through the done cycle
      push_expected(32'd100, 32'd7, 1'b0);
      push_expected(-32'sd100, 32'd7, 1'b1);
      pop_expected(eq, er, ez);
      pop_expected(eq2, er2, ez2);
      div_if.E_src1 = 32'd100; div_if.E_src2 = 32'd7; div_if.E_signed = 1'b0;
      div_if.E_start = 1'b1;
      @(posedge clk);
      #1;
      div_if.E_src1 = -32'sd100; div_if.E_signed = 1'b1;
      d1 = -1;
      d2 = -1;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         #1;
         if (n == LAT + 1) div_if.E_start = 1'b0;
         if (div_if.M_div_done) begin
            if (d1 < 0) begin
               d1 = n;
               check("b2b_first_quot", div_if.M_div_quot, eq);
               check("b2b_first_rem", div_if.M_div_rem, er);
            end else if (d2 < 0) begin
               d2 = n;
               check("b2b_second_quot", div_if.M_div_quot, eq2);
               check("b2b_second_rem", div_if.M_div_rem, er2);
            end
         end
      end
      check("b2b_first_latency", W'(d1), W'(LAT));
      check("b2b_second_latency", W'(d2), W'(2 * LAT + 1));

      // reset in the middle of a division
      issue(32'd100, 32'd7, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midreset_busy", {31'b0, div_if.M_div_busy}, '0);
      check("midreset_done", {31'b0, div_if.M_div_done}, '0);
      check("midreset_quot", div_if.M_div_quot, '0);
      check("midreset_rem", div_if.M_div_rem, '0);
      check("midreset_by_zero", {31'b0, div_if.M_div_by_zero}, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (div_if.M_div_done) saw_done = 1'b1;
      end
      check("midreset_no_done", {31'b0, saw_done}, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
